// File: rtl/piezo_tune_pkg.sv
// Shared note table, tune entry format and tune ROM contents for the piezo tune player.
package piezo_tune_pkg;

   localparam int ROM_TUNES = 4;
   localparam int ROM_NOTES = 16;
   localparam int DEFINED_TUNES = 3;
   localparam int NUM_FREQS = 8;

   typedef enum logic [3:0] {
      REST = 4'd0, G6, C7, E7, G7, D7, F7, E6, F6
   } note_e;

   localparam int FREQ_HZ [NUM_FREQS] = '{1568, 2093, 2637, 3136, 2349, 2794, 1319, 1397};

   typedef struct packed {
      note_e note;
      logic [1:0] dur_code;
      logic last;
   } tune_entry_t;

   localparam int ENTRY_W = $bits(tune_entry_t);

   typedef tune_entry_t [ROM_NOTES-1:0] tune_t;
   typedef tune_t [ROM_TUNES-1:0] rom_t;

   localparam tune_entry_t END_ENTRY = '{note: REST, dur_code: 2'd0, last: 1'b1};

   function automatic tune_entry_t te(note_e n, logic [1:0] d, logic l);
      return '{note: n, dur_code: d, last: l};
   endfunction

   // Unused slots and the spare tune row hold a terminating rest.
   function automatic rom_t build_rom();
      rom_t r;
      for (int t = 0; t < ROM_TUNES; t++)
         for (int i = 0; i < ROM_NOTES; i++)
            r[t][i] = END_ENTRY;
      r[0][0] = te(G6, 2'd1, 1'b0);
      r[0][1] = te(C7, 2'd1, 1'b0);
      r[0][2] = te(E7, 2'd1, 1'b0);
      r[0][3] = te(G7, 2'd2, 1'b0);
      r[0][4] = te(E7, 2'd0, 1'b0);
      r[0][5] = te(G7, 2'd3, 1'b1);
      r[1][0] = te(C7, 2'd0, 1'b0);
      r[1][1] = te(E7, 2'd0, 1'b0);
      r[1][2] = te(G7, 2'd0, 1'b0);
      r[1][3] = te(C7, 2'd2, 1'b1);
      r[2][0] = te(F6, 2'd1, 1'b0);
      r[2][1] = te(REST, 2'd0, 1'b0);
      r[2][2] = te(F6, 2'd1, 1'b0);
      r[2][3] = te(E6, 2'd3, 1'b1);
      return r;
   endfunction

   localparam rom_t TUNE_ROM = build_rom();

   function automatic int half_cycles(int clk_hz, note_e n);
      if (n == REST)
         return 0;
      return clk_hz / (2 * FREQ_HZ[int'(n) - 1]);
   endfunction

   function automatic int max_half(int clk_hz);
      int m;
      m = 0;
      for (int i = 0; i < NUM_FREQS; i++)
         if (clk_hz / (2 * FREQ_HZ[i]) > m)
            m = clk_hz / (2 * FREQ_HZ[i]);
      return m;
   endfunction

endpackage

// File: rtl/piezo_tune_rom.sv
// Combinational tune lookup; undefined tunes read back as a single terminating rest.
module piezo_tune_rom
   import piezo_tune_pkg::*;
#(
   parameter int TUNE_W = 2,
   parameter int IDX_W = 4
) (
   input  logic [TUNE_W-1:0]  tune,
   input  logic [IDX_W-1:0]   idx,
   output logic [ENTRY_W-1:0] entry
);

   localparam int RT_W = $clog2(ROM_TUNES);
   localparam int RN_W = $clog2(ROM_NOTES);

   always_comb begin
      entry = END_ENTRY;
      if (int'(tune) < DEFINED_TUNES && int'(idx) < ROM_NOTES)
         entry = TUNE_ROM[RT_W'(tune)][RN_W'(idx)];
   end

endmodule

// File: rtl/piezo_tune_player.sv
// Plays a selected ROM tune on a complementary piezo pair with per-note durations and gaps.
// Define PIEZO_FAST_SIM_EN to run duration/gap counters 64x faster for simulation.
module piezo_tune_player
   import piezo_tune_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int NUM_TUNES   = 4,
   parameter int MAX_NOTES   = 16,
   parameter int DUR_UNIT    = 4_194_304,
   parameter int GAP_CYC     = 262_144
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         go,
   input  logic [$clog2(NUM_TUNES)-1:0] tune_sel,
   input  logic                         stop,
   output logic                         piezo,
   output logic                         piezo_n,
   output logic                         busy,
   output logic                         done
);

   localparam int TUNE_W = $clog2(NUM_TUNES);
   localparam int IDX_W  = $clog2(MAX_NOTES);
`ifdef PIEZO_FAST_SIM_EN
   localparam int STEP = 64;
`else
   localparam int STEP = 1;
`endif
   localparam int HALF_W = $clog2(max_half(CLK_FREQ_HZ) + 1);
   localparam int TIME_W = $clog2(4 * DUR_UNIT + GAP_CYC + STEP + 1);
   localparam int HALF_TAB [16] = '{0,
      half_cycles(CLK_FREQ_HZ, G6), half_cycles(CLK_FREQ_HZ, C7),
      half_cycles(CLK_FREQ_HZ, E7), half_cycles(CLK_FREQ_HZ, G7),
      half_cycles(CLK_FREQ_HZ, D7), half_cycles(CLK_FREQ_HZ, F7),
      half_cycles(CLK_FREQ_HZ, E6), half_cycles(CLK_FREQ_HZ, F6),
      0, 0, 0, 0, 0, 0, 0};
   localparam logic [TIME_W-1:0] GAP_LIM = TIME_W'(GAP_CYC);

   typedef enum logic [1:0] {IDLE, NOTE, GAP} state_e;

   state_e            state, state_next;
   logic [TUNE_W-1:0] tune, tune_next;
   logic [IDX_W-1:0]  idx, idx_next;
   logic [TIME_W-1:0] time_cnt, time_next, time_step, dur_lim;
   logic [HALF_W-1:0] half_cnt, half_next, half_lim;
   logic              tone, tone_next, done_q, done_next;
   logic              sounding, at_end;
   tune_entry_t       entry;

   piezo_tune_rom #(.TUNE_W(TUNE_W), .IDX_W(IDX_W)) rom (
      .tune  (tune),
      .idx   (idx),
      .entry (entry)
   );

   // One shared counter times both the note duration and the following gap.
   always_comb begin
      case (entry.dur_code)
         2'd0:    dur_lim = TIME_W'(DUR_UNIT);
         2'd1:    dur_lim = TIME_W'(2 * DUR_UNIT);
         2'd2:    dur_lim = TIME_W'(3 * DUR_UNIT);
         default: dur_lim = TIME_W'(4 * DUR_UNIT);
      endcase
      half_lim  = HALF_W'(HALF_TAB[entry.note]);
      time_step = time_cnt + TIME_W'(STEP);
      sounding  = (state == NOTE) && (entry.note != REST);
      at_end    = entry.last || (idx == IDX_W'(MAX_NOTES - 1));
   end

   always_comb begin
      state_next = state;
      tune_next  = tune;
      idx_next   = idx;
      time_next  = time_cnt;
      half_next  = half_cnt;
      tone_next  = tone;
      done_next  = 1'b0;
      piezo      = sounding & tone;
      piezo_n    = sounding & ~tone;
      busy       = (state != IDLE);
      done       = done_q;
      case (state)
         IDLE: begin
            if (go && !stop) begin
               state_next = NOTE;
               tune_next  = tune_sel;
               idx_next   = '0;
               time_next  = '0;
               half_next  = '0;
               tone_next  = 1'b0;
            end
         end
         NOTE: begin
            if (stop) begin
               state_next = IDLE;
            end else begin
               if (sounding) begin
                  if (half_cnt == half_lim - 1'b1) begin
                     half_next = '0;
                     tone_next = ~tone;
                  end else begin
                     half_next = half_cnt + 1'b1;
                  end
               end
               time_next = time_step;
               if (time_step >= dur_lim) begin
                  time_next = '0;
                  half_next = '0;
                  tone_next = 1'b0;
                  if (GAP_CYC != 0) begin
                     state_next = GAP;
                  end else if (at_end) begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end else begin
                     idx_next = idx + 1'b1;
                  end
               end
            end
         end
         GAP: begin
            if (stop) begin
               state_next = IDLE;
            end else if (time_step >= GAP_LIM) begin
               time_next = '0;
               if (at_end) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = NOTE;
                  idx_next   = idx + 1'b1;
               end
            end else begin
               time_next = time_step;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tune     <= '0;
         idx      <= '0;
         time_cnt <= '0;
         half_cnt <= '0;
         tone     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_next;
         tune     <= tune_next;
         idx      <= idx_next;
         time_cnt <= time_next;
         half_cnt <= half_next;
         tone     <= tone_next;
         done_q   <= done_next;
      end
   end

endmodule

// File: tb/tb_piezo_tune_player.sv
// Scoreboard bench: per-cycle expected {piezo, piezo_n, busy, done} queued at stimulus time.
module tb_piezo_tune_player;

   localparam int DUR_UNIT = 1024;
   localparam int GAP_CYC  = 16;
`ifdef PIEZO_FAST_SIM_EN
   localparam int STEP = 64;
`else
   localparam int STEP = 1;
`endif
   localparam int DU_CYC  = (DUR_UNIT + STEP - 1) / STEP;
   localparam int GAP_EXP = (GAP_CYC + STEP - 1) / STEP;
   localparam int CLK_A   = 50_000_000;
   localparam int CLK_B   = 100_000;

   logic       clk = 1'b0;
   logic       rst, go, stop;
   logic [1:0] tune_sel;
   logic       piezo_a, piezo_n_a, busy_a, done_a;
   logic       piezo_b, piezo_n_b, busy_b, done_b;

   int total = 0;
   int bad = 0;
   logic [3:0] exp_a[$];
   logic [3:0] exp_b[$];
   logic [3:0] tl_a[$];
   logic [3:0] tl_b[$];
   int t0_freq [6] = '{1568, 2093, 2637, 3136, 2637, 3136};
   int t0_units [6] = '{2, 2, 2, 3, 1, 4};

   always #5 clk = ~clk;

   piezo_tune_player #(
      .CLK_FREQ_HZ(CLK_A), .NUM_TUNES(4), .MAX_NOTES(16),
      .DUR_UNIT(DUR_UNIT), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk(clk), .rst(rst), .go(go), .tune_sel(tune_sel), .stop(stop),
      .piezo(piezo_a), .piezo_n(piezo_n_a), .busy(busy_a), .done(done_a)
   );

   // Low clock frequency makes half-periods short enough to see toggling.
   piezo_tune_player #(
      .CLK_FREQ_HZ(CLK_B), .NUM_TUNES(4), .MAX_NOTES(16),
      .DUR_UNIT(DUR_UNIT), .GAP_CYC(GAP_CYC)
   ) dut_tone (
      .clk(clk), .rst(rst), .go(go), .tune_sel(tune_sel), .stop(stop),
      .piezo(piezo_b), .piezo_n(piezo_n_b), .busy(busy_b), .done(done_b)
   );

   function automatic logic [3:0] obs_a();
      return {piezo_a, piezo_n_a, busy_a, done_a};
   endfunction

   function automatic logic [3:0] obs_b();
      return {piezo_b, piezo_n_b, busy_b, done_b};
   endfunction

   task automatic check_output(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_a.size() != 0 && bad < 50)
         check_output("cycle_a", obs_a(), exp_a.pop_front());
      if (exp_b.size() != 0 && bad < 50)
         check_output("cycle_b", obs_b(), exp_b.pop_front());
   end

   task automatic add_note(input int half, input int units, input bit to_b);
      logic [3:0] v;
      logic p;
      for (int c = 0; c < units * DU_CYC; c++) begin
         if (half == 0) begin
            v = 4'b0010;
         end else begin
            p = ((c / half) % 2) == 1;
            v = {p, ~p, 2'b10};
         end
         if (to_b) tl_b.push_back(v);
         else tl_a.push_back(v);
      end
      for (int g = 0; g < GAP_EXP; g++) begin
         if (to_b) tl_b.push_back(4'b0010);
         else tl_a.push_back(4'b0010);
      end
   endtask

   task automatic build_tune(input int sel);
      tl_a.delete();
      tl_b.delete();
      tl_a.push_back(4'b0000);
      tl_b.push_back(4'b0000);
      if (sel == 0) begin
         for (int i = 0; i < 6; i++) begin
            add_note(CLK_A / (2 * t0_freq[i]), t0_units[i], 1'b0);
            add_note(CLK_B / (2 * t0_freq[i]), t0_units[i], 1'b1);
         end
      end else begin
         add_note(0, 1, 1'b0);
         add_note(0, 1, 1'b1);
      end
      tl_a.push_back(4'b0001);
      tl_b.push_back(4'b0001);
      for (int i = 0; i < 3; i++) begin
         tl_a.push_back(4'b0000);
         tl_b.push_back(4'b0000);
      end
   endtask

   task automatic push_expect(input int upto);
      for (int i = 0; i < tl_a.size(); i++)
         if (upto < 0 || i <= upto) exp_a.push_back(tl_a[i]);
      for (int i = 0; i < tl_b.size(); i++)
         if (upto < 0 || i <= upto) exp_b.push_back(tl_b[i]);
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) begin
         exp_a.push_back(4'b0000);
         exp_b.push_back(4'b0000);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] sel, input int upto);
      @(posedge clk);
      #1;
      go = 1'b1;
      tune_sel = sel;
      push_expect(upto);
      @(posedge clk);
      #1;
      go = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 40000) begin
         @(posedge clk);
         n++;
      end
   endtask

   initial begin
      int m;
      rst = 1'b1;
      go = 1'b0;
      stop = 1'b0;
      tune_sel = 2'd0;
      #2;
      check_output("reset_init_a", obs_a(), 4'b0000);
      check_output("reset_init_b", obs_b(), 4'b0000);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      push_idle(4);
      wait_drain();

      $display("[TB] tune 0 full playback");
      build_tune(0);
      apply_stimulus(2'd0, -1);
      wait_drain();

      $display("[TB] go while busy is ignored");
      build_tune(0);
      apply_stimulus(2'd0, -1);
      repeat (3 * DU_CYC) @(posedge clk);
      #1;
      go = 1'b1;
      tune_sel = 2'd1;
      @(posedge clk);
      #1;
      go = 1'b0;
      tune_sel = 2'd0;
      wait_drain();

      $display("[TB] abort during note 3 with simultaneous go");
      m = 4 * DU_CYC + 2 * GAP_EXP + DU_CYC / 2;
      build_tune(0);
      apply_stimulus(2'd0, m + 1);
      repeat (m) @(posedge clk);
      #1;
      stop = 1'b1;
      go = 1'b1;
      tune_sel = 2'd1;
      push_idle(6);
      @(posedge clk);
      #1;
      stop = 1'b0;
      go = 1'b0;
      tune_sel = 2'd0;
      check_output("abort_idle_a", obs_a(), 4'b0000);
      check_output("abort_idle_b", obs_b(), 4'b0000);
      wait_drain();

      $display("[TB] undefined tune plays a single rest");
      build_tune(3);
      apply_stimulus(2'd3, -1);
      wait_drain();

      $display("[TB] async reset mid-note");
      m = DU_CYC;
      build_tune(0);
      apply_stimulus(2'd0, m);
      repeat (m) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_output("reset_mid_a", obs_a(), 4'b0000);
      check_output("reset_mid_b", obs_b(), 4'b0000);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      push_idle(5);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
